// File: rtl/tlb_op_ctrl.sv
// TLB op sequencer: runs TLBR/TLBWI/TLBWR/TLBP against the tlb ports and owns CP0 Random/Wired.
// Accept in t, EXEC in t+1, done in t+2; op_ready is low while an op is in flight, so requests wait.
package tlb_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter  int N_TLB_ENTRIES = 32,
  localparam int IDX_W         = $clog2(N_TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_type,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [31:0]      cp0_entry_hi,
  input  tlb_entry_t       cp0_wrdata,
  input  logic             wired_we,
  input  logic [IDX_W-1:0] wired_wdata,
  output logic [IDX_W-1:0] random,
  output logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] tlbrw_index,
  output logic             tlbrw_we,
  output tlb_entry_t       tlbrw_wrdata,
  input  tlb_entry_t       tlbrw_rddata,
  output logic [31:0]      tlbp_entry_hi,
  input  logic [31:0]      tlbp_index,
  output logic             done,
  output logic [1:0]       done_op,
  output tlb_entry_t       rd_entry,
  output logic [31:0]      probe_index,
  output logic             flush_req
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0]       OP_TLBR  = 2'b00;
  localparam logic [1:0]       OP_TLBWI = 2'b01;
  localparam logic [1:0]       OP_TLBWR = 2'b10;
  localparam logic [1:0]       OP_TLBP  = 2'b11;
  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(N_TLB_ENTRIES - 1);

  state_t     state;
  logic [1:0] op_q;
  logic       op_is_write;

  assign op_is_write = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);

  // Random never drops below Wired; a Wired write restarts it from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      random <= RAND_MAX;
      wired  <= '0;
    end else if (wired_we) begin
      wired  <= wired_wdata;
      random <= RAND_MAX;
    end else if (random <= wired) begin
      random <= RAND_MAX;
    end else begin
      random <= random - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_ready      <= 1'b1;
      op_q          <= OP_TLBR;
      tlbrw_index   <= '0;
      tlbrw_we      <= 1'b0;
      tlbrw_wrdata  <= '0;
      tlbp_entry_hi <= '0;
      done          <= 1'b0;
      done_op       <= 2'b00;
      rd_entry      <= '0;
      probe_index   <= '0;
      flush_req     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            op_q          <= op_type;
            // TLBWR samples Random before any same-edge Wired write resets it.
            tlbrw_index   <= (op_type == OP_TLBWR) ? random : cp0_index;
            tlbp_entry_hi <= cp0_entry_hi;
            tlbrw_wrdata  <= cp0_wrdata;
            tlbrw_we      <= (op_type == OP_TLBWI) || (op_type == OP_TLBWR);
            op_ready      <= 1'b0;
            state         <= EXEC;
          end
        end
        EXEC: begin
          tlbrw_we <= 1'b0;
          if (op_q == OP_TLBR) rd_entry <= tlbrw_rddata;
          if (op_q == OP_TLBP) probe_index <= tlbp_index;
          done      <= 1'b1;
          done_op   <= op_q;
          flush_req <= op_is_write;
          state     <= DONE;
        end
        DONE: begin
          done      <= 1'b0;
          flush_req <= 1'b0;
          op_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          tlbrw_we  <= 1'b0;
          done      <= 1'b0;
          flush_req <= 1'b0;
          op_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural TLB array on the read/write/probe ports.
module tb_tlb_op_ctrl;
  import tlb_pkg::*;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_type;
  logic [4:0]  cp0_index;
  logic [31:0] cp0_entry_hi;
  tlb_entry_t  cp0_wrdata;
  logic        wired_we;
  logic [4:0]  wired_wdata;
  logic [4:0]  random;
  logic [4:0]  wired;
  logic [4:0]  tlbrw_index;
  logic        tlbrw_we;
  tlb_entry_t  tlbrw_wrdata;
  tlb_entry_t  tlbrw_rddata;
  logic [31:0] tlbp_entry_hi;
  logic [31:0] tlbp_index;
  logic        done;
  logic [1:0]  done_op;
  tlb_entry_t  rd_entry;
  logic [31:0] probe_index;
  logic        flush_req;

  int checks = 0;
  int errors = 0;

  tlb_op_ctrl #(.N_TLB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi), .cp0_wrdata(cp0_wrdata),
    .wired_we(wired_we), .wired_wdata(wired_wdata),
    .random(random), .wired(wired),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wrdata(tlbrw_wrdata),
    .tlbrw_rddata(tlbrw_rddata),
    .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .done(done), .done_op(done_op), .rd_entry(rd_entry),
    .probe_index(probe_index), .flush_req(flush_req)
  );

  always #5 clk = ~clk;

  // TLB array: combinational read and probe, write on the clock edge.
  tlb_entry_t mem [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      mem[i]      = '0;
      mem[i].vpn2 = 19'h40000 | 19'(i);
      mem[i].asid = 8'hff;
    end
  end

  always @(posedge clk) if (tlbrw_we) mem[tlbrw_index] <= tlbrw_wrdata;

  assign tlbrw_rddata = mem[tlbrw_index];

  always_comb begin
    tlbp_index = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--)
      if (mem[i].vpn2 == tlbp_entry_hi[31:13] &&
          (mem[i].g || mem[i].asid == tlbp_entry_hi[7:0]))
        tlbp_index = 32'(i);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge in IDLE; leaves at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] hi,
                        input tlb_entry_t d, input logic exp_we, input logic exp_flush);
    op_valid = 1'b1; op_type = op; cp0_index = idx; cp0_entry_hi = hi; cp0_wrdata = d;
    chk("idle_op_ready", 128'(op_ready), 128'(1));
    @(negedge clk);
    op_valid = 1'b0;
    chk("exec_we", 128'(tlbrw_we), 128'(exp_we));
    if (exp_we) begin
      chk("exec_index", 128'(tlbrw_index), 128'(idx));
      chk("exec_wrdata", 128'(tlbrw_wrdata), 128'(d));
    end
    chk("exec_op_ready", 128'(op_ready), 128'(0));
    chk("exec_done", 128'(done), 128'(0));
    @(negedge clk);
    chk("done_pulse", 128'(done), 128'(1));
    chk("done_op", 128'(done_op), 128'(op));
    chk("done_flush", 128'(flush_req), 128'(exp_flush));
    chk("done_we", 128'(tlbrw_we), 128'(0));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [31:0] hi;
    tlb_entry_t  data;
    logic        exp_we;
    logic        exp_flush;
    tlb_entry_t  exp_rd;
    logic [31:0] exp_probe;
  } vec_t;

  vec_t vecs [8];
  tlb_entry_t d5, d12, d17, d20;

  initial begin
    int n;
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    d5  = '{vpn2:19'h12345, asid:8'h3c, g:1'b0, pfn0:20'habcde, c0:3'd3, d0:1'b1, v0:1'b1,
            pfn1:20'h13579, c1:3'd2, d1:1'b0, v1:1'b1};
    d12 = '{vpn2:19'h00777, asid:8'h55, g:1'b1, pfn0:20'h00042, c0:3'd2, d0:1'b0, v0:1'b1,
            pfn1:20'h00043, c1:3'd3, d1:1'b1, v1:1'b0};
    d17 = '{vpn2:19'h2a2a2, asid:8'h11, g:1'b0, pfn0:20'h55555, c0:3'd1, d0:1'b1, v0:1'b0,
            pfn1:20'haaaaa, c1:3'd0, d1:1'b1, v1:1'b1};
    d20 = '{vpn2:19'h0f0f0, asid:8'h22, g:1'b0, pfn0:20'h12121, c0:3'd3, d0:1'b1, v0:1'b1,
            pfn1:20'h34343, c1:3'd3, d1:1'b1, v1:1'b1};

    vecs[0] = '{2'b01, 5'd5,  32'h0,                     d5,  1'b1, 1'b1, '0,  32'h0};
    vecs[1] = '{2'b00, 5'd5,  32'h0,                     '0,  1'b0, 1'b0, d5,  32'h0};
    vecs[2] = '{2'b11, 5'd0,  {19'h12345, 5'd0, 8'h3c},  '0,  1'b0, 1'b0, '0,  32'd5};
    vecs[3] = '{2'b11, 5'd0,  {19'h12345, 5'd0, 8'h3d},  '0,  1'b0, 1'b0, '0,  32'h8000_0000};
    vecs[4] = '{2'b01, 5'd12, 32'h0,                     d12, 1'b1, 1'b1, '0,  32'h0};
    vecs[5] = '{2'b00, 5'd12, 32'h0,                     '0,  1'b0, 1'b0, d12, 32'h0};
    vecs[6] = '{2'b11, 5'd0,  {19'h00777, 5'd0, 8'h99},  '0,  1'b0, 1'b0, '0,  32'd12};
    vecs[7] = '{2'b11, 5'd0,  {19'h54321, 5'd0, 8'h3c},  '0,  1'b0, 1'b0, '0,  32'h8000_0000};

    rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; cp0_index = '0; cp0_entry_hi = '0;
    cp0_wrdata = '0; wired_we = 1'b0; wired_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_random", 128'(random), 128'(31));
    chk("rst_wired", 128'(wired), 128'(0));
    chk("rst_op_ready", 128'(op_ready), 128'(1));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_we", 128'(tlbrw_we), 128'(0));
    chk("rst_flush", 128'(flush_req), 128'(0));
    rst = 1'b0;

    // Idle with Wired=0: Random counts 30..0 then wraps to 31.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("idle_random", 128'(random), 128'(31 - (k % 32)));
      chk("idle_done", 128'(done), 128'(0));
    end

    n = 0;
    while (random != 5'd3 && n < 64) begin @(negedge clk); n++; end
    chk("wait_random3", 128'(random), 128'(3));
    wired_we = 1'b1; wired_wdata = 5'd8;
    @(negedge clk);
    wired_we = 1'b0;
    chk("wired_set", 128'(wired), 128'(8));
    chk("wired_random_top", 128'(random), 128'(31));
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("wired_random", 128'(random), 128'(31 - (k % 24)));
    end

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].idx, vecs[i].hi, vecs[i].data, vecs[i].exp_we, vecs[i].exp_flush);
      if (vecs[i].op == 2'b00) chk("tlbr_rd_entry", 128'(rd_entry), 128'(vecs[i].exp_rd));
      if (vecs[i].op == 2'b11) chk("tlbp_probe", 128'(probe_index), 128'(vecs[i].exp_probe));
      @(negedge clk);
      chk("post_done", 128'(done), 128'(0));
      chk("post_flush", 128'(flush_req), 128'(0));
    end
    chk("rd_entry_hold", 128'(rd_entry), 128'(d12));

    // TLBWR with a same-cycle Wired write: index uses Random before the reset to 31.
    n = 0;
    while (random != 5'd17 && n < 64) begin @(negedge clk); n++; end
    chk("wait_random17", 128'(random), 128'(17));
    op_valid = 1'b1; op_type = 2'b10; cp0_wrdata = d17; cp0_index = 5'd2;
    wired_we = 1'b1; wired_wdata = 5'd8;
    @(negedge clk);
    op_valid = 1'b0; wired_we = 1'b0;
    chk("tlbwr_we", 128'(tlbrw_we), 128'(1));
    chk("tlbwr_index", 128'(tlbrw_index), 128'(17));
    chk("tlbwr_random", 128'(random), 128'(31));
    @(negedge clk);
    chk("tlbwr_done", 128'(done), 128'(1));
    chk("tlbwr_done_op", 128'(done_op), 128'(2));
    chk("tlbwr_flush", 128'(flush_req), 128'(1));
    @(negedge clk);
    run_op(2'b00, 5'd17, 32'h0, '0, 1'b0, 1'b0);
    chk("tlbwr_readback", 128'(rd_entry), 128'(d17));
    @(negedge clk);

    // Held request: accepted every third cycle.
    op_valid = 1'b1; op_type = 2'b00; cp0_index = 5'd5;
    for (int k = 0; k < 9; k++) begin
      chk("b2b_op_ready", 128'(op_ready), 128'((k % 3) == 0));
      chk("b2b_done", 128'(done), 128'((k % 3) == 2));
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("b2b_rd_entry", 128'(rd_entry), 128'(d5));
    @(negedge clk);

    // Reset during EXEC: write already issued stays, no done/flush follows.
    op_valid = 1'b1; op_type = 2'b01; cp0_index = 5'd20; cp0_wrdata = d20;
    @(negedge clk);
    op_valid = 1'b0;
    chk("rst_exec_we", 128'(tlbrw_we), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_op_ready", 128'(op_ready), 128'(1));
    chk("rst_mid_we", 128'(tlbrw_we), 128'(0));
    for (int k = 0; k < 3; k++) begin
      chk("rst_mid_done", 128'(done), 128'(0));
      chk("rst_mid_flush", 128'(flush_req), 128'(0));
      @(negedge clk);
    end
    run_op(2'b00, 5'd20, 32'h0, '0, 1'b0, 1'b0);
    chk("rst_mid_committed", 128'(rd_entry), 128'(d20));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
